// File: rtl/one_index_streamer_pkg.sv
// ============================================================================
// Module      : one_index_streamer_pkg
// Description : Shared definitions for the one-index streamer: FSM state
//               encoding and a constant clog2 helper used to validate the
//               index width against the vector width at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package one_index_streamer_pkg;

    // Streamer FSM: IDLE waits for a vector, EMIT presents one beat per cycle.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration only.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : one_index_streamer_pkg

`default_nettype wire

// File: rtl/one_index_streamer_lsb_priority_enc.sv
// ============================================================================
// Module      : lsb_priority_enc
// Description : Combinational priority encoder over an N-bit vector. Reports
//               the position of the lowest set bit (highest when MSB_FIRST=1),
//               whether any bit is set, and a one-hot mask selecting that bit
//               so the caller can clear it.
// Ports       : vec        [N]    vector to encode
//               index      [LOGN] selected bit position (0 when vec==0)
//               any        [1]    vec has at least one set bit
//               clear_mask [N]    one-hot of the selected bit (0 when vec==0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_priority_enc #(
    parameter int N         = 8,
    parameter int LOGN      = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic [N-1:0]    vec,
    output logic [LOGN-1:0] index,
    output logic            any,
    output logic [N-1:0]    clear_mask
);

    import one_index_streamer_pkg::*;

    always_comb begin
        index      = '0;
        clear_mask = '0;
        any        = |vec;
        // Scan so that the winning bit is the last one written: scanning
        // upwards leaves the highest set bit, downwards leaves the lowest.
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    index = LOGN'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    index = LOGN'(i);
                end
            end
        end
        clear_mask[index] = any;
    end

endmodule : lsb_priority_enc

`default_nettype wire

// File: rtl/one_index_streamer.sv
// ============================================================================
// Module      : one_index_streamer
// Description : Accepts an N-bit occupancy vector over valid/ready and emits
//               the index of every set bit, one per cycle, lowest first (or
//               highest first when MSB_FIRST=1). An all-zero vector produces a
//               single beat flagged out_empty. Back-to-back vectors stream
//               without a bubble.
// Ports       : clk        [1]      rising-edge clock
//               rst_n      [1]      asynchronous active-low reset
//               in_valid   [1]      in_seq offered
//               in_ready   [1]      vector can be accepted this cycle
//               in_seq     [N]      occupancy vector
//               out_valid  [1]      output beat is meaningful
//               out_ready  [1]      downstream consumes the beat
//               out_idx    [LOGN]   index of the current set bit
//               out_ord    [LOGN+1] ordinal of this index within its vector
//               out_last   [1]      final beat of the current vector
//               out_empty  [1]      vector was all zeros
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_index_streamer
    import one_index_streamer_pkg::*;
#(
    parameter int N         = 8,
    parameter int LOGN      = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_seq,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGN-1:0] out_idx,
    output logic [LOGN:0]   out_ord,
    output logic            out_last,
    output logic            out_empty
);

    generate
        if ((N < 2) || (LOGN != clog2_f(N)) || ((1 << LOGN) != N)) begin : g_bad_params
            $error("one_index_streamer: N must be a power of two >= 2 and LOGN must equal clog2(N)");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_pending;
    logic              r_empty;
    logic [LOGN:0]     r_ord;

    logic [LOGN-1:0]   w_enc_idx;
    logic              w_enc_any;
    logic [N-1:0]      w_clear_mask;
    logic              w_single;
    logic              w_beat;
    logic              w_accept;

    lsb_priority_enc #(
        .N         (N),
        .LOGN      (LOGN),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec        (r_pending),
        .index      (w_enc_idx),
        .any        (w_enc_any),
        .clear_mask (w_clear_mask)
    );

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_single = w_enc_any && ((r_pending & (r_pending - N'(1))) == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and stream outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_empty   = 1'b0;
        out_idx     = w_enc_idx;
        out_ord     = r_ord;
        in_ready    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_last  = w_single || r_empty;
                out_empty = r_empty;
                // A new vector may be taken on the edge that retires the last
                // beat, so consecutive vectors stream without an idle cycle.
                in_ready  = out_ready && out_last;
                if (out_ready && out_last && !in_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_beat   = out_valid && out_ready;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Pending vector, empty flag and ordinal counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_empty   <= 1'b0;
            r_ord     <= '0;
        end else if (w_accept) begin
            r_pending <= in_seq;
            r_empty   <= (in_seq == '0);
            r_ord     <= '0;
        end else if (w_beat) begin
            if (out_last) begin
                r_pending <= '0;
                r_empty   <= 1'b0;
                r_ord     <= '0;
            end else begin
                r_pending <= r_pending & ~w_clear_mask;
                r_ord     <= r_ord + (LOGN + 1)'(1);
            end
        end
    end

endmodule : one_index_streamer

`default_nettype wire

// File: tb/tb_one_index_streamer.sv
// ============================================================================
// Module      : tb_one_index_streamer
// Description : Self-checking bench for one_index_streamer. Two instances
//               (ascending and descending order) share the input stream; a
//               queue-based reference model derives expected beats from the
//               set bits of each accepted vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_one_index_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_seq;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_last_a, out_empty_a;
    logic [2:0] out_idx_a;
    logic [3:0] out_ord_a;
    logic       in_ready_m, out_valid_m, out_last_m, out_empty_m;
    logic [2:0] out_idx_m;
    logic [3:0] out_ord_m;

    logic [9:0] obs_a, obs_m;
    assign obs_a = {out_valid_a, out_idx_a, out_ord_a, out_last_a, out_empty_a};
    assign obs_m = {out_valid_m, out_idx_m, out_ord_m, out_last_m, out_empty_m};

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] q_asc[$];
    logic [9:0] q_desc[$];

    always #5 clk = ~clk;

    one_index_streamer #(.N(8), .LOGN(3), .MSB_FIRST(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_seq(in_seq),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_idx(out_idx_a), .out_ord(out_ord_a),
        .out_last(out_last_a), .out_empty(out_empty_a)
    );

    one_index_streamer #(.N(8), .LOGN(3), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_seq(in_seq),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .out_ord(out_ord_m),
        .out_last(out_last_m), .out_empty(out_empty_m)
    );

    // Pack an expected beat in the same layout as obs_a / obs_m.
    function automatic logic [9:0] bt(input int v, input int idx, input int ord,
                                      input int last, input int empty);
        return {v[0], idx[2:0], ord[3:0], last[0], empty[0]};
    endfunction

    // Drive inputs on the falling edge and let combinational outputs settle;
    // the handshake then resolves on the following rising edge.
    task automatic step(input logic v, input logic [7:0] s, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_seq    = s;
        out_ready = r;
        #1;
    endtask

    // Reference model: the beats one vector produces, in both orders.
    task automatic model_push(input logic [7:0] v);
        int cnt;
        int k;
        cnt = $countones(v);
        if (cnt == 0) begin
            q_asc.push_back(bt(1, 0, 0, 1, 1));
            q_desc.push_back(bt(1, 0, 0, 1, 1));
        end else begin
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    q_asc.push_back(bt(1, i, k, (k == cnt - 1) ? 1 : 0, 0));
                    k++;
                end
            end
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    q_desc.push_back(bt(1, i, k, (k == cnt - 1) ? 1 : 0, 0));
                    k++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_seq = 8'h00; out_ready = 1'b0;
        #12;
        n_cmp++;
        if (obs_a !== 10'h000) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", obs_a, 10'h000);
        end
        n_cmp++;
        if (in_ready_a !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs_a !== 10'h000) begin
            n_err++; $display("FAIL reset_release_idle: got %h expected %h", obs_a, 10'h000);
        end
    endtask

    task automatic test_sparse();
        int eidx[3] = '{1, 3, 4};
        logic erdy[3] = '{1'b0, 1'b0, 1'b1};
        step(1'b1, 8'b00011010, 1'b1);
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (obs_a !== bt(1, eidx[b], b, (b == 2) ? 1 : 0, 0)) begin
                n_err++; $display("FAIL sparse_beat%0d: got %h expected %h", b, obs_a,
                                  bt(1, eidx[b], b, (b == 2) ? 1 : 0, 0));
            end
            n_cmp++;
            if (in_ready_a !== erdy[b]) begin
                n_err++; $display("FAIL sparse_in_ready%0d: got %b expected %b", b, in_ready_a, erdy[b]);
            end
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL sparse_idle_after: got %b expected 0", out_valid_a);
        end
    endtask

    task automatic test_msb_first();
        int eidx[3] = '{4, 3, 1};
        step(1'b1, 8'b00011010, 1'b1);
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (obs_m !== bt(1, eidx[b], b, (b == 2) ? 1 : 0, 0)) begin
                n_err++; $display("FAIL msb_beat%0d: got %h expected %h", b, obs_m,
                                  bt(1, eidx[b], b, (b == 2) ? 1 : 0, 0));
            end
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_empty();
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs_a !== bt(1, 0, 0, 1, 1)) begin
            n_err++; $display("FAIL empty_beat: got %h expected %h", obs_a, bt(1, 0, 0, 1, 1));
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            n_err++; $display("FAIL empty_then_idle: got %b expected 01", {out_valid_a, in_ready_a});
        end
    endtask

    task automatic test_stall();
        logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       r;
        logic       prev_stall;
        logic [9:0] prev_obs;
        int         n;
        n = 0; prev_stall = 1'b0; prev_obs = '0;
        step(1'b1, 8'hFF, 1'b1);
        for (int c = 0; c < 64 && n < 8; c++) begin
            r = pat[c % 4];
            step(1'b0, 8'h00, r);
            if (prev_stall) begin
                n_cmp++;
                if (obs_a !== prev_obs) begin
                    n_err++; $display("FAIL stall_hold%0d: got %h expected %h", c, obs_a, prev_obs);
                end
            end
            if (r) begin
                n_cmp++;
                if (obs_a !== bt(1, n, n, (n == 7) ? 1 : 0, 0)) begin
                    n_err++; $display("FAIL stall_beat%0d: got %h expected %h", n, obs_a,
                                      bt(1, n, n, (n == 7) ? 1 : 0, 0));
                end
                n_cmp++;
                if (obs_m !== bt(1, 7 - n, n, (n == 7) ? 1 : 0, 0)) begin
                    n_err++; $display("FAIL stall_msb_beat%0d: got %h expected %h", n, obs_m,
                                      bt(1, 7 - n, n, (n == 7) ? 1 : 0, 0));
                end
                n++;
            end
            prev_stall = !r;
            prev_obs   = obs_a;
        end
        n_cmp++;
        if (n != 8) begin
            n_err++; $display("FAIL stall_beat_count: got %0d expected 8", n);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL stall_idle_after: got %b expected 0", out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'b10000001, 1'b1);
        step(1'b1, 8'b00000100, 1'b1);
        n_cmp++;
        if ({obs_a, in_ready_a} !== {bt(1, 0, 0, 0, 0), 1'b0}) begin
            n_err++; $display("FAIL b2b_beat0: got %h expected %h", {obs_a, in_ready_a},
                              {bt(1, 0, 0, 0, 0), 1'b0});
        end
        step(1'b1, 8'b00000100, 1'b1);
        n_cmp++;
        if ({obs_a, in_ready_a} !== {bt(1, 7, 1, 1, 0), 1'b1}) begin
            n_err++; $display("FAIL b2b_beat1: got %h expected %h", {obs_a, in_ready_a},
                              {bt(1, 7, 1, 1, 0), 1'b1});
        end
        n_cmp++;
        if (obs_m !== bt(1, 0, 1, 1, 0)) begin
            n_err++; $display("FAIL b2b_msb_beat1: got %h expected %h", obs_m, bt(1, 0, 1, 1, 0));
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs_a !== bt(1, 2, 0, 1, 0)) begin
            n_err++; $display("FAIL b2b_beat2: got %h expected %h", obs_a, bt(1, 2, 0, 1, 0));
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_after: got %b expected 0", out_valid_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] vecs[40];
        int         vi;
        logic       offering;
        logic       rdy;
        logic       exp_rdy;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       vecs[i] = 8'h00;
                1:       vecs[i] = 8'hFF;
                default: vecs[i] = 8'($urandom);
            endcase
        end
        vi = 0; offering = 1'b0;
        for (int cyc = 0; cyc < 3000 && !(vi == 40 && q_asc.size() == 0); cyc++) begin
            if (!offering && vi < 40 && $urandom_range(0, 3) != 0) offering = 1'b1;
            rdy = ($urandom_range(0, 3) != 0);
            step(offering, offering ? vecs[vi] : 8'($urandom), rdy);
            exp_rdy = (q_asc.size() == 0) || (rdy && q_asc.size() == 1);
            n_cmp++;
            if (in_ready_a !== exp_rdy) begin
                n_err++; $display("FAIL rand_in_ready c%0d: got %b expected %b", cyc, in_ready_a, exp_rdy);
            end
            if (q_asc.size() == 0) begin
                n_cmp++;
                if ({out_valid_a, out_valid_m} !== 2'b00) begin
                    n_err++; $display("FAIL rand_idle c%0d: got %b expected 00", cyc, {out_valid_a, out_valid_m});
                end
            end else begin
                n_cmp++;
                if ({obs_a, obs_m} !== {q_asc[0], q_desc[0]}) begin
                    n_err++; $display("FAIL rand_beat c%0d: got %h/%h expected %h/%h", cyc,
                                      obs_a, obs_m, q_asc[0], q_desc[0]);
                end
                if (rdy) begin
                    void'(q_asc.pop_front());
                    void'(q_desc.pop_front());
                end
            end
            if (offering && exp_rdy) begin
                model_push(vecs[vi]);
                vi++;
                offering = 1'b0;
            end
        end
        n_cmp++;
        if (vi != 40 || q_asc.size() != 0) begin
            n_err++; $display("FAIL rand_drain: got %0d vectors / %0d beats left expected 40 / 0", vi, q_asc.size());
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hF0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs_a !== bt(1, 4, 0, 0, 0)) begin
            n_err++; $display("FAIL rstmid_first_beat: got %h expected %h", obs_a, bt(1, 4, 0, 0, 0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            n_err++; $display("FAIL rstmid_async_drop: got %b expected 01", {out_valid_a, in_ready_a});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            n_err++; $display("FAIL rstmid_after_release: got %b expected 01", {out_valid_a, in_ready_a});
        end
        step(1'b1, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs_a !== bt(1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL rstmid_new_vector: got %h expected %h", obs_a, bt(1, 0, 0, 1, 0));
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL rstmid_idle_after: got %b expected 0", out_valid_a);
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_msb_first();
        test_empty();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_one_index_streamer

`default_nettype wire
